// File: rtl/smc_pkg.sv
// Shared types and widths for the smc_seq transistor-frame sequencer.
// SMC_SEQ_OUTREG_EN adds the HOLD state used by the optional output register stage.
package smc_pkg;

  localparam int IN_W      = 3;
  localparam int DAT_W     = 8;
  localparam int SUM_W     = 10;
  localparam int FRAME_LEN = 6;
  localparam int CNT_W     = 3;

`ifdef SMC_SEQ_OUTREG_EN
  typedef enum logic [2:0] {IDLE, LOAD, CALC, HOLD, OUT} state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, CALC, OUT} state_e;
`endif

endpackage

// File: rtl/smc_calc.sv
// Combinational ID / gm of a single transistor record, shared across all load cycles.
module smc_calc
  import smc_pkg::*;
(
  input  logic [IN_W-1:0]  w,
  input  logic [IN_W-1:0]  v_gs,
  input  logic [IN_W-1:0]  v_ds,
  output logic [DAT_W-1:0] id,
  output logic [DAT_W-1:0] gm
);

  logic [SUM_W-1:0] w_x, vds_x, v1, id_prod, gm_prod;

  always_comb begin
    w_x   = SUM_W'(w);
    vds_x = SUM_W'(v_ds);
    v1    = (v_gs == '0) ? '0 : SUM_W'(v_gs) - SUM_W'(1);
    if (v1 > vds_x) begin
      id_prod = w_x * vds_x * (SUM_W'(2) * v1 - vds_x);
      gm_prod = SUM_W'(2) * w_x * vds_x;
    end else begin
      id_prod = w_x * v1 * v1;
      gm_prod = SUM_W'(2) * w_x * v1;
    end
    // Worst case products stay below 256, so the truncated quotient fits in 8 bits.
    id = DAT_W'(id_prod / SUM_W'(3));
    gm = DAT_W'(gm_prod / SUM_W'(3));
  end

endmodule

// File: rtl/smc_seq.sv
// Frame sequencer: loads 6 transistor records, sorts ID or gm, emits a weighted average.
// Define SMC_SEQ_OUTREG_EN to add an output register stage (HOLD state, one extra cycle).
module smc_seq
  import smc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  W,
  input  logic [IN_W-1:0]  V_GS,
  input  logic [IN_W-1:0]  V_DS,
  output logic             out_valid,
  output logic [DAT_W-1:0] out_n
);

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [1:0]                          mode_q, mode_d;
  logic [FRAME_LEN-1:0][DAT_W-1:0]     id_q, id_d, gm_q, gm_d;
  logic                                out_valid_q, out_valid_d;
  logic [DAT_W-1:0]                    out_n_q, out_n_d;
  logic [DAT_W-1:0]                    rec_id, rec_gm;
  logic [FRAME_LEN-1:0][DAT_W-1:0]     srt;
  logic [DAT_W-1:0]                    tmp, a, b, c;
  logic [SUM_W-1:0]                    sum;
  logic [DAT_W-1:0]                    avg;

  smc_calc u_calc (
    .w    (W),
    .v_gs (V_GS),
    .v_ds (V_DS),
    .id   (rec_id),
    .gm   (rec_gm)
  );

  // Odd-even transposition sort, descending; FRAME_LEN passes fully sort FRAME_LEN items.
  always_comb begin
    srt = mode_q[0] ? id_q : gm_q;
    tmp = '0;
    for (int p = 0; p < FRAME_LEN; p++) begin
      for (int i = p % 2; i < FRAME_LEN - 1; i += 2) begin
        if (srt[i] < srt[i+1]) begin
          tmp      = srt[i];
          srt[i]   = srt[i+1];
          srt[i+1] = tmp;
        end
      end
    end
  end

  always_comb begin
    if (mode_q[1]) begin
      a = srt[0]; b = srt[1]; c = srt[2];
    end else begin
      a = srt[FRAME_LEN-3]; b = srt[FRAME_LEN-2]; c = srt[FRAME_LEN-1];
    end
    if (mode_q[0]) begin
      sum = SUM_W'(3) * SUM_W'(a) + SUM_W'(4) * SUM_W'(b) + SUM_W'(5) * SUM_W'(c);
      avg = DAT_W'(sum / SUM_W'(12));
    end else begin
      sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
      avg = DAT_W'(sum / SUM_W'(3));
    end
  end

`ifdef SMC_SEQ_OUTREG_EN
  logic [DAT_W-1:0] avg_q, avg_d;
  always_comb avg_d = (state_q == CALC) ? avg : avg_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) avg_q <= '0;
    else        avg_q <= avg_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    id_d    = id_q;
    gm_d    = gm_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        mode_d   = mode;
        id_d[0]  = rec_id;
        gm_d[0]  = rec_gm;
        cnt_d    = CNT_W'(1);
        state_d  = LOAD;
      end
      LOAD: if (in_valid) begin
        id_d[cnt_q] = rec_id;
        gm_d[cnt_q] = rec_gm;
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Short frame: drop what was loaded.
        cnt_d   = '0;
        state_d = IDLE;
      end
`ifdef SMC_SEQ_OUTREG_EN
      CALC: state_d = HOLD;
      HOLD: state_d = OUT;
`else
      CALC: state_d = OUT;
`endif
      OUT:  state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    out_valid_d = (state_d == OUT);
`ifdef SMC_SEQ_OUTREG_EN
    out_n_d = out_valid_d ? avg_q : '0;
`else
    out_n_d = out_valid_d ? avg : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      id_q        <= '0;
      gm_q        <= '0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      id_q        <= id_d;
      gm_q        <= gm_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

endmodule

// File: tb/tb_smc_seq.sv
// Self-checking bench for smc_seq: directed vector table, abort/reset sequences, random frames vs model.
module tb_smc_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] mode = '0;
  logic [2:0] W = '0, V_GS = '0, V_DS = '0;
  logic       out_valid;
  logic [7:0] out_n;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SMC_SEQ_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  smc_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_n     (out_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      m;
    logic [5:0][2:0] w;
    logic [5:0][2:0] vgs;
    logic [5:0][2:0] vds;
    logic [7:0]      exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: per-record MOSFET formulas, then sort the chosen metric and average.
  function automatic int model(input logic [1:0] m, input logic [5:0][2:0] w,
                               input logic [5:0][2:0] vgs, input logic [5:0][2:0] vds);
    int q[$];
    int v1, ww, vd, idv, gmv, a, b, c;
    for (int i = 0; i < 6; i++) begin
      ww = int'(w[i]); vd = int'(vds[i]);
      v1 = (vgs[i] == 0) ? 0 : int'(vgs[i]) - 1;
      if (v1 > vd) begin
        idv = ww * vd * (2 * v1 - vd) / 3;
        gmv = ww * 2 * vd / 3;
      end else begin
        idv = ww * v1 * v1 / 3;
        gmv = ww * 2 * v1 / 3;
      end
      q.push_back(m[0] ? idv : gmv);
    end
    q.rsort();
    if (m[1]) begin a = q[0]; b = q[1]; c = q[2]; end
    else      begin a = q[3]; b = q[4]; c = q[5]; end
    return m[0] ? (3 * a + 4 * b + 5 * c) / 12 : (a + b + c) / 3;
  endfunction

  task automatic drive_recs(input logic [1:0] m, input logic [5:0][2:0] w,
                            input logic [5:0][2:0] vgs, input logic [5:0][2:0] vds, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      mode     = (i == 0) ? m : ~m;
      W        = w[i];
      V_GS     = vgs[i];
      V_DS     = vds[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [5:0][2:0] w,
                           input logic [5:0][2:0] vgs, input logic [5:0][2:0] vds,
                           input int exp, input string nm, input bit junk);
    int k;
    drive_recs(m, w, vgs, vds, 6);
    in_valid = junk;
    W = 3'($urandom); V_GS = 3'($urandom); V_DS = 3'($urandom); mode = 2'($urandom);
    chk({nm, "_early"}, int'(out_valid), 0);
    k = 0;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin k = j; break; end
    end
    chk({nm, "_lat"}, k, LAT);
    chk({nm, "_out"}, int'(out_n), exp);
    @(posedge clk); #1;
    chk({nm, "_after"}, int'({out_valid, out_n}), 0);
  endtask

  initial begin
    int  bad;
    logic [1:0]      rm;
    logic [5:0][2:0] rw, rg, rd;

    tbl[0] = '{m:2'b11, w:{6{3'd3}}, vgs:{6{3'd3}}, vds:{6{3'd3}}, exp:8'd4};
    tbl[1] = '{m:2'b11, w:{6{3'd3}}, vgs:{3'd3,3'd3,3'd3,3'd5,3'd5,3'd5},
               vds:{3'd3,3'd3,3'd3,3'd1,3'd1,3'd1}, exp:8'd7};
    tbl[2] = '{m:2'b01, w:{6{3'd3}}, vgs:{3'd3,3'd3,3'd3,3'd5,3'd5,3'd5},
               vds:{3'd3,3'd3,3'd3,3'd1,3'd1,3'd1}, exp:8'd4};
    tbl[3] = '{m:2'b00, w:{6{3'd3}}, vgs:{3'd3,3'd3,3'd3,3'd5,3'd5,3'd5},
               vds:{3'd3,3'd3,3'd3,3'd1,3'd1,3'd1}, exp:8'd2};
    tbl[4] = '{m:2'b11, w:{6{3'd3}}, vgs:{3'd6,3'd5,3'd4,3'd3,3'd2,3'd1}, vds:{6{3'd7}}, exp:8'd15};
    tbl[5] = '{m:2'b01, w:{6{3'd3}}, vgs:{3'd6,3'd5,3'd4,3'd3,3'd2,3'd1}, vds:{6{3'd7}}, exp:8'd1};
    tbl[6] = '{m:2'b10, w:{6{3'd3}}, vgs:{3'd6,3'd5,3'd4,3'd3,3'd2,3'd1}, vds:{6{3'd7}}, exp:8'd8};
    tbl[7] = '{m:2'b11, w:{6{3'd7}}, vgs:{6{3'd7}}, vds:{3'd7,3'd7,3'd7,3'd5,3'd5,3'd5}, exp:8'd84};
    tbl[8] = '{m:2'b00, w:{6{3'd7}}, vgs:{6{3'd7}}, vds:{3'd7,3'd7,3'd7,3'd5,3'd5,3'd5}, exp:8'd23};
    tbl[9] = '{m:2'b11, w:{6{3'd7}}, vgs:{6{3'd0}}, vds:{6{3'd3}}, exp:8'd0};

    #3;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_n", int'(out_n), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_frame(tbl[i].m, tbl[i].w, tbl[i].vgs, tbl[i].vds, int'(tbl[i].exp),
                $sformatf("vec%0d", i), 1'b0);

    // Short frame is discarded, then a full frame still works.
    drive_recs(tbl[0].m, tbl[0].w, tbl[0].vgs, tbl[0].vds, 4);
    in_valid = 1'b0;
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    chk("abort_no_out", bad, 0);
    run_frame(tbl[0].m, tbl[0].w, tbl[0].vgs, tbl[0].vds, 4, "after_abort", 1'b0);

    // Reset pulsed while the frame is in CALC.
    drive_recs(tbl[1].m, tbl[1].w, tbl[1].vgs, tbl[1].vds, 6);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("calc_rst_valid", int'(out_valid), 0);
    chk("calc_rst_n", int'(out_n), 0);
    #2 rst_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (out_valid || out_n != 0) bad++;
    end
    chk("calc_rst_quiet", bad, 0);
    run_frame(tbl[2].m, tbl[2].w, tbl[2].vgs, tbl[2].vds, 4, "after_rst", 1'b0);

    for (int r = 0; r < 40; r++) begin
      rm = 2'($urandom);
      rw = 18'($urandom);
      rg = 18'($urandom);
      rd = 18'($urandom);
      run_frame(rm, rw, rg, rd, model(rm, rw, rg, rd), $sformatf("rand%0d", r), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
